// File: rtl/code_sequencer.sv
// Code-line sequencer for the training controller: holds a small (op, layer) program
// and steps through it under the controller's count_reset / code_active / code_reset requests.
module code_sequencer #(
   parameter int OP_SIZE     = 4,
   parameter int PROG_DEPTH  = 8,
   parameter int EPOCH_COUNT = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               prog_we,
   input  logic [7:0]         prog_addr,
   input  logic [OP_SIZE-1:0] prog_op,
   input  logic [31:0]        prog_arg,
   input  logic [7:0]         prog_len,
   input  logic               start,
   input  logic               count_reset,
   input  logic               code_active,
   input  logic               code_reset,
   output logic [OP_SIZE-1:0] op,
   output logic [31:0]        code_count,
   output logic [31:0]        code_index,
   output logic               enable,
   output logic               busy,
   output logic               done,
   output logic [31:0]        epoch_left
);

   localparam int          PC_W    = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
   localparam logic [8:0]  DEPTH_L = 9'(PROG_DEPTH);
   localparam logic [31:0] EPOCHS  = (EPOCH_COUNT == 0) ? 32'd1 : 32'(EPOCH_COUNT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [31:0]       r_code_count;
   logic [31:0]       w_count_nxt;
   logic [31:0]       r_epoch_left;
   logic [31:0]       w_epoch_nxt;
   logic [8:0]        r_len;
   logic [8:0]        w_len_nxt;
   logic              w_wr_ok;
   logic              w_last_line;
   logic              w_run;

   logic [OP_SIZE-1:0] r_prog_op  [PROG_DEPTH];
   logic [31:0]        r_prog_arg [PROG_DEPTH];

   assign w_run       = (r_state == S_RUN);
   assign w_wr_ok     = prog_we && !w_run && ({1'b0, prog_addr} < DEPTH_L);
   assign w_last_line = ({{(9 - PC_W){1'b0}}, r_pc} == (r_len - 9'd1));

   // Program store is deliberately left out of reset so a reload is not needed after reset.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_prog_op[prog_addr[PC_W-1:0]]  <= prog_op;
         r_prog_arg[prog_addr[PC_W-1:0]] <= prog_arg;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_count_nxt = r_code_count;
      w_epoch_nxt = r_epoch_left;
      w_len_nxt   = r_len;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start && (prog_len != 8'd0)) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = '0;
               w_count_nxt = 32'd0;
               w_epoch_nxt = EPOCHS;
               w_len_nxt   = ({1'b0, prog_len} > DEPTH_L) ? DEPTH_L : {1'b0, prog_len};
            end
         end
         S_RUN: begin
            // code_reset outranks the line-advance request raised in the same cycle.
            if (code_reset) begin
               w_pc_nxt    = '0;
               w_count_nxt = 32'd0;
               if (r_epoch_left == 32'd1) begin
                  w_state_nxt = S_DONE;
                  w_epoch_nxt = 32'd0;
               end else begin
                  w_epoch_nxt = r_epoch_left - 32'd1;
               end
            end else if (count_reset) begin
               w_count_nxt = 32'd0;
               if (code_active) begin
                  w_pc_nxt = w_last_line ? '0 : r_pc + 1'b1;
               end
            end else if (r_code_count != 32'hFFFF_FFFF) begin
               w_count_nxt = r_code_count + 32'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_pc         <= '0;
         r_code_count <= 32'd0;
         r_epoch_left <= 32'd0;
         r_len        <= 9'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_code_count <= w_count_nxt;
         r_epoch_left <= w_epoch_nxt;
         r_len        <= w_len_nxt;
      end
   end

   assign enable     = w_run;
   assign busy       = w_run;
   assign done       = (r_state == S_DONE);
   assign op         = w_run ? r_prog_op[r_pc] : '0;
   assign code_index = w_run ? r_prog_arg[r_pc] : 32'd0;
   assign code_count = r_code_count;
   assign epoch_left = r_epoch_left;

endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer: directed scenarios against hand-derived values, then
// randomized traffic against a line/epoch reference model.
module tb_code_sequencer;

   logic        clk;
   logic        reset;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [3:0]  prog_op;
   logic [31:0] prog_arg;
   logic [7:0]  prog_len;
   logic        start;
   logic        count_reset;
   logic        code_active;
   logic        code_reset;
   logic [3:0]  op;
   logic [31:0] code_count;
   logic [31:0] code_index;
   logic        enable;
   logic        busy;
   logic        done;
   logic [31:0] epoch_left;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [3:0]  m_op  [8];
   logic [31:0] m_arg [8];
   bit          m_run;
   bit          m_done;
   int          m_pc;
   int          m_len;
   logic [31:0] m_cnt;
   logic [31:0] m_ep;

   code_sequencer #(.OP_SIZE(4), .PROG_DEPTH(8), .EPOCH_COUNT(3)) dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_op(prog_op), .prog_arg(prog_arg), .prog_len(prog_len), .start(start),
      .count_reset(count_reset), .code_active(code_active), .code_reset(code_reset),
      .op(op), .code_count(code_count), .code_index(code_index), .enable(enable),
      .busy(busy), .done(done), .epoch_left(epoch_left)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_step();
      if (!m_run && prog_we && prog_addr < 8) begin
         m_op[prog_addr[2:0]]  = prog_op;
         m_arg[prog_addr[2:0]] = prog_arg;
      end
      if (reset) begin
         m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_ep = 0; m_len = 0;
      end else if (!m_run) begin
         if (start && prog_len != 0) begin
            m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; m_ep = 3;
            m_len = (prog_len > 8) ? 8 : int'(prog_len);
         end
      end else if (code_reset) begin
         m_pc = 0; m_cnt = 0;
         if (m_ep == 1) begin
            m_run = 0; m_done = 1; m_ep = 0;
         end else begin
            m_ep = m_ep - 1;
         end
      end else if (count_reset) begin
         m_cnt = 0;
         if (code_active) m_pc = (m_pc + 1) % m_len;
      end else if (m_cnt != 32'hFFFF_FFFF) begin
         m_cnt = m_cnt + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      prog_we = 0; start = 0; count_reset = 0; code_active = 0; code_reset = 0;
   endtask

   task automatic write_line(input int a, input logic [3:0] o, input logic [31:0] g);
      prog_we = 1; prog_addr = a[7:0]; prog_op = o; prog_arg = g;
      tick();
      prog_we = 0;
   endtask

   task automatic start_run(input logic [7:0] len);
      prog_len = len; start = 1;
      tick();
      start = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs(); prog_addr = 0; prog_op = 0; prog_arg = 0; prog_len = 0;
      tick(); tick();
      reset = 0;
      total++; if (op !== 4'd0) begin bad++; $display("FAIL reset_op got=%0h want=0", op); end
      total++; if (code_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", code_count); end
      total++; if (code_index !== 32'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", code_index); end
      total++; if ({enable, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {enable, busy, done}); end
      total++; if (epoch_left !== 32'd0) begin bad++; $display("FAIL reset_epoch got=%0d want=0", epoch_left); end
   endtask

   task automatic test_load_start();
      write_line(0, 4'd1, 32'd0);
      write_line(1, 4'd2, 32'd1);
      start_run(8'd2);
      total++; if ({enable, busy, done} !== 3'b110) begin bad++; $display("FAIL start_flags got=%b want=110", {enable, busy, done}); end
      total++; if (op !== 4'd1) begin bad++; $display("FAIL start_op got=%0d want=1", op); end
      total++; if (code_index !== 32'd0) begin bad++; $display("FAIL start_index got=%0d want=0", code_index); end
      total++; if (code_count !== 32'd0) begin bad++; $display("FAIL start_count got=%0d want=0", code_count); end
      total++; if (epoch_left !== 32'd3) begin bad++; $display("FAIL start_epoch got=%0d want=3", epoch_left); end
   endtask

   task automatic test_line_advance();
      for (int k = 0; k < 12; k++) begin
         total++; if (code_count !== 32'(k)) begin bad++; $display("FAIL line0_count got=%0d want=%0d", code_count, k); end
         if (k == 11) begin count_reset = 1; code_active = 1; end
         tick();
         idle_inputs();
      end
      total++; if (op !== 4'd2) begin bad++; $display("FAIL adv_op got=%0d want=2", op); end
      total++; if (code_index !== 32'd1) begin bad++; $display("FAIL adv_index got=%0d want=1", code_index); end
      total++; if (code_count !== 32'd0) begin bad++; $display("FAIL adv_count got=%0d want=0", code_count); end
   endtask

   task automatic test_epochs();
      for (int e = 2; e >= 0; e--) begin
         tick(); tick();
         total++; if (code_count !== 32'd2) begin bad++; $display("FAIL ep_line1_count got=%0d want=2", code_count); end
         code_reset = 1;
         tick();
         idle_inputs();
         if (e > 0) begin
            total++; if (op !== 4'd1) begin bad++; $display("FAIL ep_restart_op got=%0d want=1", op); end
            total++; if (epoch_left !== 32'(e)) begin bad++; $display("FAIL ep_left got=%0d want=%0d", epoch_left, e); end
            total++; if (code_count !== 32'd0) begin bad++; $display("FAIL ep_count got=%0d want=0", code_count); end
            repeat (11) tick();
            count_reset = 1; code_active = 1;
            tick();
            idle_inputs();
            total++; if (op !== 4'd2) begin bad++; $display("FAIL ep_line1_op got=%0d want=2", op); end
         end else begin
            total++; if ({enable, busy, done} !== 3'b001) begin bad++; $display("FAIL done_flags got=%b want=001", {enable, busy, done}); end
            total++; if (op !== 4'd0) begin bad++; $display("FAIL done_op got=%0d want=0", op); end
            total++; if (code_index !== 32'd0) begin bad++; $display("FAIL done_index got=%0d want=0", code_index); end
            total++; if (epoch_left !== 32'd0) begin bad++; $display("FAIL done_epoch got=%0d want=0", epoch_left); end
         end
      end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL done_hold got=%b want=1", done); end
   endtask

   task automatic test_wrap();
      start_run(8'd2);
      total++; if ({enable, done} !== 2'b10) begin bad++; $display("FAIL restart_flags got=%b want=10", {enable, done}); end
      count_reset = 1; code_active = 1;
      tick();
      total++; if (op !== 4'd2) begin bad++; $display("FAIL wrap_line1 got=%0d want=2", op); end
      tick();
      idle_inputs();
      total++; if (op !== 4'd1) begin bad++; $display("FAIL wrap_op got=%0d want=1", op); end
      total++; if (code_index !== 32'd0) begin bad++; $display("FAIL wrap_index got=%0d want=0", code_index); end
      total++; if (epoch_left !== 32'd3) begin bad++; $display("FAIL wrap_epoch got=%0d want=3", epoch_left); end
   endtask

   task automatic test_writes_ignored();
      write_line(0, 4'd7, 32'd77);
      total++; if (op !== 4'd1) begin bad++; $display("FAIL run_write_op got=%0d want=1", op); end
      total++; if (code_count !== 32'd1) begin bad++; $display("FAIL run_write_count got=%0d want=1", code_count); end
      count_reset = 1;
      tick();
      idle_inputs();
      total++; if (code_count !== 32'd0) begin bad++; $display("FAIL cnt_reset_count got=%0d want=0", code_count); end
      total++; if (op !== 4'd1) begin bad++; $display("FAIL cnt_reset_op got=%0d want=1", op); end
      code_reset = 1;
      repeat (3) tick();
      idle_inputs();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL to_done got=%b want=1", done); end
      write_line(9, 4'd5, 32'd55);
      write_line(8, 4'd6, 32'd66);
      start_run(8'd2);
      total++; if (op !== 4'd1) begin bad++; $display("FAIL oob_line0_op got=%0d want=1", op); end
      count_reset = 1; code_active = 1;
      tick();
      idle_inputs();
      total++; if (op !== 4'd2) begin bad++; $display("FAIL oob_line1_op got=%0d want=2", op); end
      total++; if (code_index !== 32'd1) begin bad++; $display("FAIL oob_line1_index got=%0d want=1", code_index); end
      reset = 1; tick(); reset = 0;
      start_run(8'd0);
      total++; if ({enable, busy, done} !== 3'b000) begin bad++; $display("FAIL len0_flags got=%b want=000", {enable, busy, done}); end
   endtask

   task automatic test_simultaneous();
      start_run(8'd2);
      tick();
      code_reset = 1; count_reset = 1; code_active = 1;
      tick();
      idle_inputs();
      total++; if (op !== 4'd1) begin bad++; $display("FAIL simul_op got=%0d want=1", op); end
      total++; if (epoch_left !== 32'd2) begin bad++; $display("FAIL simul_epoch got=%0d want=2", epoch_left); end
      total++; if (code_count !== 32'd0) begin bad++; $display("FAIL simul_count got=%0d want=0", code_count); end
   endtask

   task automatic test_reset_mid_run();
      repeat (3) tick();
      reset = 1;
      tick();
      reset = 0;
      total++; if ({enable, busy, done} !== 3'b000) begin bad++; $display("FAIL midrst_flags got=%b want=000", {enable, busy, done}); end
      total++; if ({op, code_index} !== 36'd0) begin bad++; $display("FAIL midrst_outs got=%0h want=0", {op, code_index}); end
      total++; if ({code_count, epoch_left} !== 64'd0) begin bad++; $display("FAIL midrst_regs got=%0h want=0", {code_count, epoch_left}); end
      start_run(8'd2);
      total++; if (op !== 4'd1) begin bad++; $display("FAIL midrst_prog got=%0d want=1", op); end
   endtask

   task automatic test_random();
      logic [3:0]  e_op;
      logic [31:0] e_idx;
      reset = 1; tick(); reset = 0;
      for (int a = 0; a < 8; a++) write_line(a, 4'($urandom_range(0, 15)), $urandom);
      for (int n = 0; n < 500; n++) begin
         reset       = ($urandom_range(0, 99) == 0);
         start       = ($urandom_range(0, 9) == 0);
         prog_len    = 8'($urandom_range(0, 10));
         prog_we     = ($urandom_range(0, 5) == 0);
         prog_addr   = 8'($urandom_range(0, 11));
         prog_op     = 4'($urandom_range(0, 15));
         prog_arg    = $urandom;
         code_reset  = ($urandom_range(0, 24) == 0);
         count_reset = ($urandom_range(0, 2) == 0);
         code_active = 1'($urandom_range(0, 1));
         tick();
         e_op  = m_run ? m_op[m_pc] : 4'd0;
         e_idx = m_run ? m_arg[m_pc] : 32'd0;
         total++; if (op !== e_op) begin bad++; $display("FAIL rnd_op n=%0d got=%0h want=%0h", n, op, e_op); end
         total++; if (code_index !== e_idx) begin bad++; $display("FAIL rnd_index n=%0d got=%0h want=%0h", n, code_index, e_idx); end
         total++; if (code_count !== m_cnt) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, code_count, m_cnt); end
         total++; if (epoch_left !== m_ep) begin bad++; $display("FAIL rnd_epoch n=%0d got=%0d want=%0d", n, epoch_left, m_ep); end
         total++; if ({enable, busy, done} !== {m_run, m_run, m_done}) begin
            bad++; $display("FAIL rnd_flags n=%0d got=%b want=%b", n, {enable, busy, done}, {m_run, m_run, m_done});
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_op[i] = 0; m_arg[i] = 0;
      end
      m_run = 0; m_done = 0; m_pc = 0; m_len = 0; m_cnt = 0; m_ep = 0;
      test_reset();
      test_load_start();
      test_line_advance();
      test_epochs();
      test_wrap();
      test_writes_ignored();
      test_simultaneous();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
